// File: rtl/sms_pkg.sv
// Shared constants and FSM state encoding for the SMS ROM loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sms_pkg;

  // Default cartridge geometry: 16 KB banks, 512-byte copier header.
  localparam int DEF_AW        = 22;
  localparam int DEF_BANK_BITS = 14;
  localparam int DEF_HDR_BYTES = 512;

  // Loader FSM states, kept as plain 3-bit constants.
  typedef logic [2:0] state_t;

  localparam state_t ST_INIT   = 3'd0;
  localparam state_t ST_IDLE   = 3'd1;
  localparam state_t ST_LOAD   = 3'd2;
  localparam state_t ST_WRITE  = 3'd3;
  localparam state_t ST_FINISH = 3'd4;
  localparam state_t ST_HOLD   = 3'd5;
  localparam state_t ST_RUN    = 3'd6;

endpackage

// File: rtl/sms_pow2_mask.sv
// Rounds a bank count up to the next power of two and returns it minus one.
// Latency: 2..W+2 cycles from start to the one-cycle done pulse.
// Backpressure: none; a start while busy restarts with the new count.
module sms_pow2_mask
  import sms_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic         start,
  input  logic [W:0]   n,
  output logic         done,
  output logic [W-1:0] mask
);

  logic         busy;
  logic [W:0]   p;
  logic [W:0]   n_q;

  // Double p until it covers n; p[W] set means the largest possible count is reached.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      p    <= '0;
      n_q  <= '0;
      mask <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        busy <= 1'b1;
        p    <= {{W{1'b0}}, 1'b1};
        n_q  <= n;
      end else if (busy) begin
        if ((p >= n_q) || p[W]) begin
          busy <= 1'b0;
          done <= 1'b1;
          mask <= W'(p - 1'b1);
        end else begin
          p <= p << 1;
        end
      end
    end
  end

endmodule

// File: rtl/sms_rom_loader.sv
// Streams a downloaded ROM image into SDRAM, then maps console reads through a bank mask.
// Latency: mem_we rises the cycle after ioctl_wr; RUN-mode mem_addr is combinational from sys_addr.
// Backpressure: ioctl_wait rises with ioctl_wr and falls the cycle after mem_ready.
module sms_rom_loader
  import sms_pkg::*;
#(
  parameter int AW          = DEF_AW,
  parameter int BANK_BITS   = DEF_BANK_BITS,
  parameter int HDR_BYTES   = DEF_HDR_BYTES,
  parameter int INIT_CYCLES = 5000000,
  parameter int POST_CYCLES = 16
) (
  input  logic                    clk_sys,
  input  logic                    reset,
  input  logic                    ioctl_download,
  input  logic                    ioctl_wr,
  input  logic [24:0]             ioctl_addr,
  input  logic [7:0]              ioctl_dout,
  output logic                    ioctl_wait,
  input  logic [AW-1:0]           sys_addr,
  output logic [AW-1:0]           mem_addr,
  output logic [7:0]              mem_din,
  output logic                    mem_we,
  input  logic                    mem_ready,
  output logic [AW-BANK_BITS-1:0] cart_mask,
  output logic                    dbr,
  output logic                    sys_reset
);

  localparam int             MW        = AW - BANK_BITS;
  localparam logic [AW:0]    HDR_W     = (AW + 1)'(HDR_BYTES);
  localparam logic [AW-1:0]  HDR_A     = AW'(HDR_BYTES);
  localparam logic [AW:0]    BANK_MASK = (AW + 1)'((1 << BANK_BITS) - 1);
  localparam logic [31:0]    INIT_LAST = 32'(INIT_CYCLES - 1);
  localparam logic [31:0]    POST_LAST = 32'(POST_CYCLES - 1);

  state_t        state;
  logic [31:0]   cnt;
  logic [AW-1:0] lat_addr;
  logic [7:0]    lat_data;
  logic [AW:0]   byte_count;
  logic          wait_q;
  logic          hdr;
  logic          fin_busy;
  logic          dl_prev;

  logic          hdr_c;
  logic [AW:0]   eff_len;
  logic [AW:0]   n_shift;
  logic [MW:0]   n_c;
  logic          pm_start;
  logic          pm_done;
  logic [MW-1:0] pm_mask;
  logic [AW-1:0] run_addr;
  logic          unused_addr_hi;

  // File offsets above the ROM window never reach SDRAM.
  assign unused_addr_hi = ^ioctl_addr[24:AW];

  // A copier header shows up as exactly HDR_BYTES left over past a bank boundary.
  assign hdr_c   = ((byte_count & BANK_MASK) == HDR_W);
  assign eff_len = hdr_c ? (byte_count - HDR_W) : byte_count;
  assign n_shift = (eff_len + BANK_MASK) >> BANK_BITS;
  assign n_c     = (n_shift == '0) ? {{MW{1'b0}}, 1'b1} : (MW + 1)'(n_shift);

  assign pm_start = (state == ST_FINISH) && !fin_busy;

  sms_pow2_mask #(
    .W (MW)
  ) u_pow2 (
    .clk_sys (clk_sys),
    .reset   (reset),
    .start   (pm_start),
    .n       (n_c),
    .done    (pm_done),
    .mask    (pm_mask)
  );

  // Console reads fold the bank index through the mask and skip the header.
  assign run_addr   = {sys_addr[AW-1:BANK_BITS] & cart_mask, sys_addr[BANK_BITS-1:0]}
                    + (hdr ? HDR_A : '0);
  assign mem_addr   = (state == ST_RUN) ? run_addr : lat_addr;
  assign mem_din    = lat_data;
  assign sys_reset  = (state != ST_RUN);
  // The stall must be visible in the same cycle as the strobe that caused it.
  assign ioctl_wait = wait_q | ((state == ST_LOAD) && ioctl_wr);

  // Loader FSM: power-on hold, byte-by-byte download, mask computation, post-load hold.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= ST_INIT;
      cnt        <= '0;
      lat_addr   <= '0;
      lat_data   <= '0;
      byte_count <= '0;
      wait_q     <= 1'b0;
      mem_we     <= 1'b0;
      cart_mask  <= '1;
      hdr        <= 1'b0;
      dbr        <= 1'b0;
      fin_busy   <= 1'b0;
      dl_prev    <= 1'b0;
    end else begin
      mem_we  <= 1'b0;
      dl_prev <= ioctl_download;
      case (state)
        ST_INIT: begin
          if (cnt == INIT_LAST) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_IDLE: begin
          if (ioctl_download) begin
            state      <= ST_LOAD;
            byte_count <= '0;
          end
        end
        ST_LOAD: begin
          if (ioctl_wr) begin
            lat_addr <= ioctl_addr[AW-1:0];
            lat_data <= ioctl_dout;
            wait_q   <= 1'b1;
            mem_we   <= 1'b1;
            state    <= ST_WRITE;
            // Track the highest offset seen; AW+1 bits hold 2^AW without wrapping.
            if ({1'b0, ioctl_addr[AW-1:0]} >= byte_count) begin
              byte_count <= {1'b0, ioctl_addr[AW-1:0]} + 1'b1;
            end
          end else if (!ioctl_download) begin
            state <= ST_FINISH;
          end
        end
        ST_WRITE: begin
          // A download that ended mid-write is noticed only once the write lands.
          if (mem_ready) begin
            wait_q <= 1'b0;
            state  <= ioctl_download ? ST_LOAD : ST_FINISH;
          end
        end
        ST_FINISH: begin
          if (!fin_busy) begin
            hdr      <= hdr_c;
            fin_busy <= 1'b1;
          end else if (pm_done) begin
            cart_mask <= pm_mask;
            dbr       <= 1'b1;
            fin_busy  <= 1'b0;
            cnt       <= '0;
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cnt == POST_LAST) begin
            state <= ST_RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RUN: begin
          if (ioctl_download && !dl_prev) begin
            state      <= ST_LOAD;
            byte_count <= '0;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_sms_rom_loader.sv
// Directed bench for sms_rom_loader with a scaled geometry (256-byte banks, 32-byte header).
// Latency: n/a.
// Backpressure: mem_ready answers each mem_we three cycles later.
module tb_sms_rom_loader;
  import sms_pkg::*;

  localparam int AW   = 12;
  localparam int BB   = 8;
  localparam int HDR  = 32;
  localparam int INIT = 100;
  localparam int POST = 16;
  localparam int BANK = 1 << BB;
  localparam int MW   = AW - BB;

  logic          clk_sys = 1'b0;
  logic          reset = 1'b1;
  logic          ioctl_download = 1'b0;
  logic          ioctl_wr = 1'b0;
  logic [24:0]   ioctl_addr = '0;
  logic [7:0]    ioctl_dout = '0;
  logic          ioctl_wait;
  logic [AW-1:0] sys_addr = '0;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic          mem_we;
  logic          mem_ready;
  logic [MW-1:0] cart_mask;
  logic          dbr;
  logic          sys_reset;

  int              vectors = 0;
  int              miscompares = 0;
  int              we_seen = 0;
  int              exp_mask = 0;
  bit              exp_hdr = 1'b0;
  bit              chk_en = 1'b0;
  bit              resp_en = 1'b1;
  bit              prev_ready = 1'b0;
  logic [AW+7:0]   exp_q[$];

  sms_rom_loader #(
    .AW          (AW),
    .BANK_BITS   (BB),
    .HDR_BYTES   (HDR),
    .INIT_CYCLES (INIT),
    .POST_CYCLES (POST)
  ) dut (
    .clk_sys        (clk_sys),
    .reset          (reset),
    .ioctl_download (ioctl_download),
    .ioctl_wr       (ioctl_wr),
    .ioctl_addr     (ioctl_addr),
    .ioctl_dout     (ioctl_dout),
    .ioctl_wait     (ioctl_wait),
    .sys_addr       (sys_addr),
    .mem_addr       (mem_addr),
    .mem_din        (mem_din),
    .mem_we         (mem_we),
    .mem_ready      (mem_ready),
    .cart_mask      (cart_mask),
    .dbr            (dbr),
    .sys_reset      (sys_reset)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Cartridge geometry straight from the byte count.
  function automatic void model_cart(input int bytes, output int mask, output bit h);
    int n;
    h = ((bytes % BANK) == HDR);
    n = (bytes - (h ? HDR : 0) + BANK - 1) / BANK;
    if (n < 1) n = 1;
    mask = (1 << $clog2(n)) - 1;
  endfunction

  function automatic int model_addr(input int sa, input int mask, input bit h);
    return (((sa / BANK) & mask) * BANK + (sa % BANK) + (h ? HDR : 0)) % (1 << AW);
  endfunction

  // SDRAM stand-in: completes each write three cycles after mem_we.
  initial begin
    mem_ready = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (resp_en && mem_we === 1'b1) begin
        repeat (3) @(posedge clk_sys);
        #1 mem_ready = 1'b1;
        @(posedge clk_sys);
        #1 mem_ready = 1'b0;
      end
    end
  end

  // Per-cycle scoreboard: every write matches the byte sent, and RUN mapping follows the model.
  always @(negedge clk_sys) begin : cmp
    logic [AW+7:0] e;
    if (chk_en) begin
      if (mem_we === 1'b1) begin
        we_seen++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL mem_we_unexpected: got mem_we=1 with no byte outstanding, expected 0");
        end else begin
          e = exp_q.pop_front();
          check("mem_addr_write", mem_addr, e[AW+7:8]);
          check("mem_din_write", mem_din, e[7:0]);
        end
      end
      if (resp_en) begin
        if (mem_ready === 1'b1) check("wait_during_ready", ioctl_wait, 1);
        if (prev_ready) check("wait_after_ready", ioctl_wait, 0);
      end
      prev_ready = (mem_ready === 1'b1);
      if (sys_reset === 1'b0) begin
        check("run_mem_addr", mem_addr, model_addr(int'(sys_addr), exp_mask, exp_hdr));
        check("run_cart_mask", cart_mask, exp_mask);
        check("run_dbr", dbr, 1);
      end
    end
  end

  task automatic dl_byte(input int a, input logic [7:0] d, input bit last_drop);
    logic [AW-1:0] qa;
    int budget;
    qa = AW'(a);
    @(posedge clk_sys); #1;
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'(a);
    ioctl_dout = d;
    exp_q.push_back({qa, d});
    #3 check("wait_same_cycle", ioctl_wait, 1);
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    if (last_drop) begin
      ioctl_download = 1'b0;
      check("mem_we_at_drop", mem_we, 1);
    end
    budget = 20;
    while (ioctl_wait === 1'b1 && budget > 0) begin
      if (last_drop) check("state_held_write", dut.state, ST_WRITE);
      @(posedge clk_sys); #1;
      budget--;
    end
    if (budget == 0) check("wait_release_timeout", ioctl_wait, 0);
    if (last_drop) check("finish_after_ready", dut.state, ST_FINISH);
  endtask

  task automatic wait_run(input int budget, output int cycles);
    cycles = 0;
    while (sys_reset === 1'b1 && cycles < budget) begin
      @(posedge clk_sys); #1;
      cycles++;
    end
    check("run_reached", sys_reset, 0);
  endtask

  task automatic probe(input string name, input logic [AW-1:0] sa, input logic [AW-1:0] want);
    @(posedge clk_sys); #1;
    sys_addr = sa;
    #2 check(name, mem_addr, want);
  endtask

  task automatic sweep();
    for (int i = 0; i < 16; i++) begin
      @(posedge clk_sys); #1;
      sys_addr = AW'(i * 419 + 7);
    end
    @(posedge clk_sys); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    int c;
    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_ioctl_wait", ioctl_wait, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_cart_mask", cart_mask, 4'hF);
    check("rst_dbr", dbr, 0);
    check("rst_sys_reset", sys_reset, 1);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_din, 0);
    check("rst_state", dut.state, ST_INIT);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Power-on hold lasts exactly INIT cycles.
    for (int i = 0; i < INIT; i++) begin
      check("init_sys_reset", sys_reset, 1);
      check("init_dbr", dbr, 0);
      if (i == INIT - 1) check("init_last_cycle", dut.state, ST_INIT);
      @(posedge clk_sys); #1;
    end
    check("idle_reached", dut.state, ST_IDLE);

    // Three full banks, no header.
    ioctl_download = 1'b1;
    for (int a = 0; a < 3 * BANK; a++) dl_byte(a, 8'(a * 7 + 3), 1'b0);
    ioctl_download = 1'b0;
    model_cart(3 * BANK, exp_mask, exp_hdr);
    check("a_we_count", we_seen, 3 * BANK);
    c = 0;
    while (dbr !== 1'b1 && c < 50) begin
      @(posedge clk_sys); #1;
      c++;
    end
    check("a_dbr", dbr, 1);
    wait_run(100, c);
    check("a_hold_len", c, POST);
    check("a_cart_mask", cart_mask, 4'h3);
    check("a_hdr", dut.hdr, 0);
    probe("a_addr_0", 12'h000, 12'h000);
    probe("a_addr_mid", 12'h2A5, 12'h2A5);
    probe("a_addr_wrap", 12'h400, 12'h000);
    probe("a_addr_top", 12'hFFF, 12'h3FF);
    sweep();

    // A strobe while running must be ignored.
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h123;
    #3 check("run_wr_no_wait", ioctl_wait, 0);
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    check("run_wr_stays_run", sys_reset, 0);

    // Two banks plus a copier header; download drops alongside the final mem_we.
    ioctl_download = 1'b1;
    for (int a = 0; a < 2 * BANK + HDR; a++) dl_byte(a, 8'(a ^ 'h5A), a == 2 * BANK + HDR - 1);
    model_cart(2 * BANK + HDR, exp_mask, exp_hdr);
    check("b_we_count", we_seen, 5 * BANK + HDR);
    wait_run(100, c);
    check("b_cart_mask", cart_mask, 4'h1);
    check("b_hdr", dut.hdr, 1);
    check("b_dbr", dbr, 1);
    probe("b_addr_0", 12'h000, 12'h020);
    probe("b_addr_wrap", 12'h200, 12'h020);
    probe("b_addr_bank1", 12'h1F0, 12'h210);
    sweep();

    // Zero-length download.
    ioctl_download = 1'b1;
    repeat (3) @(posedge clk_sys);
    #1 ioctl_download = 1'b0;
    model_cart(0, exp_mask, exp_hdr);
    wait_run(100, c);
    check("z_cart_mask", cart_mask, 4'h0);
    check("z_hdr", dut.hdr, 0);
    check("z_dbr", dbr, 1);
    probe("z_addr_top", 12'hFFF, 12'h0FF);
    probe("z_addr_mid", 12'h3A7, 12'h0A7);
    sweep();

    // Reset in the middle of a write.
    resp_en = 1'b0;
    ioctl_download = 1'b1;
    @(posedge clk_sys); #1;
    ioctl_wr   = 1'b1;
    ioctl_addr = 25'h005;
    ioctl_dout = 8'hA5;
    exp_q.push_back({12'h005, 8'hA5});
    #3 check("r_wait_same_cycle", ioctl_wait, 1);
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
    check("r_in_write", dut.state, ST_WRITE);
    check("r_wait_high", ioctl_wait, 1);
    reset = 1'b1;
    @(posedge clk_sys); #1;
    check("r_wait_dropped", ioctl_wait, 0);
    check("r_state_init", dut.state, ST_INIT);
    check("r_cart_mask", cart_mask, 4'hF);
    check("r_mem_we", mem_we, 0);
    check("r_sys_reset", sys_reset, 1);
    check("r_dbr", dbr, 0);
    reset = 1'b0;
    ioctl_download = 1'b0;
    check("queue_drained", exp_q.size(), 0);
    repeat (2) @(posedge clk_sys);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
